// File: rtl/seq_pkg.sv
// Shared types and default timing constants for the sequence-memory game.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ENTRY,
        ST_RESULT
    } state_t;

    typedef logic [7:0] pattern_t;

    localparam int DEF_SHOW_CYCLES   = 100_000_000;
    localparam int DEF_RESULT_CYCLES = 200_000_000;
    localparam int DEF_MAX_TRIES     = 3;

    localparam pattern_t LEDS_ALL_ON  = 8'hFF;
    localparam pattern_t LEDS_ALL_OFF = 8'h00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; done is high while the count sits at zero and it never wraps.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/seq_check.sv
// Show a captured 8-bit pattern, then let the user guess it on the switches within MAX_TRIES.
module seq_check
    import seq_pkg::*;
#(
    parameter int SHOW_CYCLES   = DEF_SHOW_CYCLES,
    parameter int RESULT_CYCLES = DEF_RESULT_CYCLES,
    parameter int MAX_TRIES     = DEF_MAX_TRIES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LD,
    input  logic [7:0] SEQ,
    input  logic [7:0] SW,
    input  logic       BTN,
    output logic [7:0] LEDS,
    output logic       BUSY,
    output logic       MISS,
    output logic       WIN,
    output logic       LOSE
);

    localparam int TW = $clog2(max_int(SHOW_CYCLES, RESULT_CYCLES) + 1);
    localparam logic [TW-1:0] SHOW_LOAD   = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] RESULT_LOAD = TW'(RESULT_CYCLES - 1);
    localparam logic [3:0]    TRIES_INIT  = 4'(MAX_TRIES);

    state_t     state_q;
    pattern_t   target_q;
    logic [3:0] tries_q;
    pattern_t   leds_q;
    logic       busy_q, miss_q, win_q, lose_q;
    logic [1:0] btn_sync_q;
    logic       btn_prev_q;

    logic          submit, guess_ok, last_try;
    logic          tmr_load, tmr_en, tmr_done;
    logic [TW-1:0] tmr_val;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btn_sync_q <= 2'b00;
            btn_prev_q <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], BTN};
            btn_prev_q <= btn_sync_q[1];
        end
    end

    // Rising edge only, so a button already held when ENTRY begins never submits.
    assign submit   = btn_sync_q[1] & ~btn_prev_q;
    assign guess_ok = (SW == target_q);
    assign last_try = (tries_q <= 4'd1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_load = LD;
                tmr_val  = SHOW_LOAD;
            end
            ST_SHOW:   tmr_en = 1'b1;
            ST_ENTRY: begin
                tmr_load = submit && (guess_ok || last_try);
                tmr_val  = RESULT_LOAD;
            end
            ST_RESULT: tmr_en = 1'b1;
            default: ;
        endcase
    end

    seq_timer #(.W(TW)) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            tries_q  <= '0;
            leds_q   <= LEDS_ALL_OFF;
            busy_q   <= 1'b0;
            miss_q   <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    leds_q <= LEDS_ALL_OFF;
                    busy_q <= 1'b0;
                    win_q  <= 1'b0;
                    lose_q <= 1'b0;
                    if (LD) begin
                        target_q <= SEQ;
                        tries_q  <= TRIES_INIT;
                        leds_q   <= SEQ;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (tmr_done) begin
                        leds_q  <= SW;
                        state_q <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    leds_q <= SW;
                    if (submit) begin
                        if (guess_ok) begin
                            win_q   <= 1'b1;
                            leds_q  <= LEDS_ALL_ON;
                            state_q <= ST_RESULT;
                        end else if (!last_try) begin
                            tries_q <= tries_q - 4'd1;
                            miss_q  <= 1'b1;
                        end else begin
                            lose_q  <= 1'b1;
                            leds_q  <= LEDS_ALL_OFF;
                            state_q <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (tmr_done) begin
                        win_q   <= 1'b0;
                        lose_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        leds_q  <= LEDS_ALL_OFF;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LEDS = leds_q;
    assign BUSY = busy_q;
    assign MISS = miss_q;
    assign WIN  = win_q;
    assign LOSE = lose_q;

endmodule

// File: tb/tb_seq_check.sv
// Directed scoreboard bench: stimulus queues expected result events, a negedge monitor pops and compares them.
module tb_seq_check;

    localparam int SHOW_CYCLES   = 10;
    localparam int RESULT_CYCLES = 20;
    localparam int MAX_TRIES     = 3;

    typedef enum logic [1:0] {EV_MISS, EV_WIN, EV_LOSE, EV_IDLE} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] leds;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       LD  = 1'b0;
    logic [7:0] SEQ = 8'h00;
    logic [7:0] SW  = 8'h00;
    logic       BTN = 1'b0;
    logic [7:0] LEDS;
    logic       BUSY, MISS, WIN, LOSE;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic prev_win = 1'b0, prev_lose = 1'b0, prev_busy = 1'b0;

    seq_check #(
        .SHOW_CYCLES   (SHOW_CYCLES),
        .RESULT_CYCLES (RESULT_CYCLES),
        .MAX_TRIES     (MAX_TRIES)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .LD   (LD),
        .SEQ  (SEQ),
        .SW   (SW),
        .BTN  (BTN),
        .LEDS (LEDS),
        .BUSY (BUSY),
        .MISS (MISS),
        .WIN  (WIN),
        .LOSE (LOSE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_t kind, input logic [7:0] leds);
        exp_t e;
        e.kind = kind;
        e.leds = leds;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_t kind);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %s leds=0x%0h, expected no event", kind.name(), LEDS);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.leds !== LEDS) begin
                n_err++;
                $display("FAIL event: got %s leds=0x%0h, expected %s leds=0x%0h",
                         kind.name(), LEDS, e.kind.name(), e.leds);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            prev_win  = 1'b0;
            prev_lose = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (WIN || LOSE || MISS)
                check("exclusive_flags", {29'd0, WIN, LOSE, MISS},
                      {29'd0, WIN, LOSE & ~WIN, MISS & ~WIN & ~LOSE});
            if (MISS) observe(EV_MISS);
            if (WIN && !prev_win) observe(EV_WIN);
            if (LOSE && !prev_lose) observe(EV_LOSE);
            if (!BUSY && prev_busy) observe(EV_IDLE);
            prev_win  = WIN;
            prev_lose = LOSE;
            prev_busy = BUSY;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_round(input logic [7:0] s);
        LD  = 1'b1;
        SEQ = s;
        tick();
        LD  = 1'b0;
        SEQ = 8'h00;
    endtask

    task automatic wait_entry();
        repeat (SHOW_CYCLES) tick();
    endtask

    task automatic press();
        BTN = 1'b1;
        repeat (3) tick();
        BTN = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && BUSY; i++) tick();
        check(name, BUSY, 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int lat;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {LEDS, BUSY, MISS, WIN, LOSE}, 0);
        RST = 1'b0;
        repeat (2) tick();
        check("idle_outputs", {LEDS, BUSY, MISS, WIN, LOSE}, 0);

        // Test 1: show A5 for exactly SHOW_CYCLES, then mirror SW
        SW = 8'h5A;
        start_round(8'hA5);
        check("t1_busy", BUSY, 1);
        check("t1_leds_show", LEDS, 8'hA5);
        cnt = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (LEDS == 8'hA5) cnt++;
            else break;
        end
        check("t1_show_len", cnt, SHOW_CYCLES);
        check("t1_leds_sw", LEDS, 8'h5A);
        SW = 8'hC3;
        tick();
        check("t1_leds_follow", LEDS, 8'hC3);

        // Test 2: correct guess wins, FF for RESULT_CYCLES, back to idle
        SW = 8'hA5;
        expect_ev(EV_WIN, 8'hFF);
        expect_ev(EV_IDLE, 8'h00);
        BTN = 1'b1;
        lat = 0;
        while (!WIN && lat < 10) begin
            tick();
            lat++;
        end
        check("t2_win_latency", lat, 3);
        BTN = 1'b0;
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (WIN && LEDS == 8'hFF) cnt++;
            else break;
        end
        check("t2_result_len", cnt, RESULT_CYCLES);
        check("t2_idle", {LEDS, BUSY, WIN, LOSE}, 0);

        // Test 3: three wrong guesses -> two misses then lose
        start_round(8'hA5);
        wait_entry();
        SW = 8'h00;
        expect_ev(EV_MISS, 8'h00);
        expect_ev(EV_MISS, 8'h00);
        expect_ev(EV_LOSE, 8'h00);
        expect_ev(EV_IDLE, 8'h00);
        press();
        press();
        check("t3_after_two_busy", {BUSY, LOSE}, 2'b10);
        press();
        check("t3_lose", {LOSE, WIN}, 2'b10);
        check("t3_lose_leds", LEDS, 8'h00);
        wait_idle("t3_idle");

        // Test 4: LD mid-round is ignored
        start_round(8'hA5);
        repeat (3) tick();
        LD = 1'b1; SEQ = 8'h3C;
        tick();
        LD = 1'b0;
        check("t4_leds_show", LEDS, 8'hA5);
        repeat (SHOW_CYCLES - 4) tick();
        check("t4_busy_entry", BUSY, 1);
        SW = 8'h11;
        LD = 1'b1; SEQ = 8'h3C;
        tick();
        LD = 1'b0;
        tick();
        check("t4_leds_entry", LEDS, 8'h11);
        SW = 8'hA5;
        expect_ev(EV_WIN, 8'hFF);
        expect_ev(EV_IDLE, 8'h00);
        press();
        wait_idle("t4_idle");

        // Test 5: button held across SHOW->ENTRY does not submit
        start_round(8'hA5);
        SW = 8'hA5;
        repeat (2) tick();
        BTN = 1'b1;
        repeat (SHOW_CYCLES + 6) tick();
        check("t5_no_submit", {BUSY, WIN, LOSE}, 3'b100);
        BTN = 1'b0;
        repeat (3) tick();
        SW = 8'h00;
        tick();
        expect_ev(EV_MISS, 8'h00);
        press();
        check("t5_one_compare", exp_q.size(), 0);
        SW = 8'hA5;
        expect_ev(EV_WIN, 8'hFF);
        expect_ev(EV_IDLE, 8'h00);
        press();
        wait_idle("t5_idle");

        // Test 6: reset mid-SHOW and mid-RESULT, then a clean round
        start_round(8'hA5);
        repeat (4) tick();
        RST = 1'b1;
        #1;
        check("t6_rst_show", {LEDS, BUSY, MISS, WIN, LOSE}, 0);
        tick();
        RST = 1'b0;
        tick();
        start_round(8'hA5);
        wait_entry();
        SW = 8'hA5;
        expect_ev(EV_WIN, 8'hFF);
        press();
        check("t6_in_result", {WIN, LEDS}, 9'h1FF);
        RST = 1'b1;
        #1;
        check("t6_rst_result", {LEDS, BUSY, MISS, WIN, LOSE}, 0);
        tick();
        RST = 1'b0;
        repeat (5) tick();
        check("t6_no_stale", {LEDS, BUSY, MISS, WIN, LOSE}, 0);
        start_round(8'h0F);
        check("t6_new_show", {BUSY, LEDS}, 9'h10F);
        wait_entry();
        SW = 8'h0F;
        expect_ev(EV_WIN, 8'hFF);
        expect_ev(EV_IDLE, 8'h00);
        press();
        wait_idle("t6_idle");

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_check.md
SEQ_CHECK -- requirements
Module: seq_check

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 100_000_000, number of clock cycles the captured sequence is displayed (1 s at 100 MHz).
REQ-002 SHALL have parameter RESULT_CYCLES, default 200_000_000, number of cycles the WIN/LOSE result is held.
REQ-003 SHALL have parameter MAX_TRIES, default 3, range 1..15, guesses allowed per round.
REQ-004 SHALL have a single clock and an asynchronous, active-high reset: CLK in 1 (rising-edge system clock), then RST in 1 (asynchronous, active-high reset).
REQ-005 SHALL have port LD in 1: one-cycle strobe from the upstream storage stage marking SEQ valid.
REQ-006 SHALL have port SEQ in 8: target pattern, sampled only when LD=1.
REQ-007 SHALL have port SW in 8: user guess switches.
REQ-008 SHALL have port BTN in 1: debounced submit button, asynchronous to CLK.
REQ-009 SHALL have port LEDS out 8: display pattern.
REQ-010 SHALL have port BUSY out 1: high in every state except IDLE.
REQ-011 SHALL have port MISS out 1: one-cycle pulse on a wrong guess that leaves tries remaining.
REQ-012 SHALL have ports WIN out 1 and LOSE out 1: round result, held for the whole of RESULT.

Function
REQ-013 SHALL implement the states IDLE, SHOW, ENTRY and RESULT.
REQ-014 In IDLE: LEDS=0, WIN=LOSE=MISS=0, BUSY=0; LD=1 captures SEQ into the target register, loads tries_left=MAX_TRIES, clears the timer and enters SHOW on the next cycle.
REQ-015 In SHOW: LEDS=target for exactly SHOW_CYCLES cycles, then ENTRY.
REQ-016 In ENTRY: LEDS=SW combinationally mirrored (one register stage permitted, fixed).
REQ-017 SHALL pass BTN through a 2-flop synchroniser; a submit event is the cycle where the synchronised BTN is 1 and its previous value is 0.
REQ-018 A submit in ENTRY with SW==target SHALL set WIN=1 and enter RESULT on the next cycle.
REQ-019 A submit in ENTRY with SW!=target and tries_left>1 SHALL decrement tries_left, pulse MISS for one cycle and remain in ENTRY.
REQ-020 A submit in ENTRY with SW!=target and tries_left==1 SHALL set LOSE=1 and enter RESULT.
REQ-021 In RESULT: LEDS=8'hFF if WIN else 8'h00, held for exactly RESULT_CYCLES cycles; then WIN=LOSE=0 and IDLE.
REQ-022 LD outside IDLE SHALL be ignored; the target SHALL NOT change mid-round.
REQ-023 BTN edges outside ENTRY SHALL be ignored and SHALL NOT be queued; a button held across the SHOW-to-ENTRY transition SHALL NOT count as a submit.
REQ-024 WIN and LOSE SHALL never be high simultaneously; MISS SHALL never coincide with WIN or LOSE.
REQ-025 SHALL use a timer wide enough for max(SHOW_CYCLES, RESULT_CYCLES) that counts without wrap-around; a terminal count equal to the parameter marks the exit cycle.

Reset
REQ-026 RST=1 SHALL immediately force IDLE, target=0, tries_left=0, timer=0, both synchroniser flops=0 and all outputs=0, regardless of the current state.
REQ-027 After RST deasserts, the first LD SHALL start a fresh round; no stale result SHALL appear.

Structure
REQ-028 Shared package seq_pkg SHALL hold the state enum type, the 8-bit pattern typedef and the default timing constants.
REQ-029 The down-counter SHALL be a sub-module seq_timer (load, enable, done) instantiated once; the FSM and compare logic SHALL stay in seq_check.

Verification
REQ-030 Directed test 1: SHOW_CYCLES=10; LD with SEQ=8'hA5 -> BUSY=1 next cycle, LEDS=8'hA5 for 10 cycles, then LEDS follows SW.
REQ-031 Directed test 2: in ENTRY, SW=8'hA5 then BTN pulse -> WIN=1 within 4 cycles, LEDS=8'hFF for RESULT_CYCLES, then IDLE with BUSY=0.
REQ-032 Directed test 3: MAX_TRIES=3, SW=8'h00 submitted three times -> MISS pulses twice, then LOSE=1 on the third submit, LEDS=0.
REQ-033 Directed test 4: LD with SEQ=8'h3C during SHOW and during ENTRY -> target stays 8'hA5; SW=8'hA5 still wins.
REQ-034 Directed test 5: BTN held high from SHOW into ENTRY -> no submit; release then press -> exactly one compare.
REQ-035 Directed test 6: RST asserted mid-SHOW and mid-RESULT -> all outputs 0 in the same cycle; a following LD with 8'h0F runs a normal round.
